// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio output path.
//   sched_state_t    : sample scheduler state (IDLE, PRIME, RUN, MUTE)
//   MAX_WIDTH        : widest sample the helper functions handle (32 bits)
//   mid_code()       : midscale (silence) code for an offset-binary sample
//   signed_to_offset : two's-complement -> offset-binary (MSB flip)
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        MUTE  = 2'd3
    } sched_state_t;

    // Midscale of a width-bit offset-binary code: only the MSB set.
    function automatic logic [MAX_WIDTH-1:0] mid_code(input int unsigned width);
        mid_code = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
    endfunction

    // Offset binary is two's complement with the sign bit inverted, so the
    // conversion is a single XOR with the midscale code.
    function automatic logic [MAX_WIDTH-1:0] signed_to_offset(
        input logic [MAX_WIDTH-1:0] sample,
        input int unsigned          width
    );
        signed_to_offset = sample ^ mid_code(width);
    endfunction

endpackage

// File: rtl/rate_divider.sv
// -----------------------------------------------------------------------------
// rate_divider
// Free-running period divider. While run is high the counter advances every
// clk and tick is asserted in the cycle where cnt >= div, after which the
// counter restarts at 0. While run is low the counter is held at 0.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   run  : enable counting; low clears the counter
//   div  : period minus 1, in clk cycles (div=0 ticks every cycle)
//   tick : combinational tick, valid in the cycle it is asserted
// -----------------------------------------------------------------------------
module rate_divider #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] cnt_next;

    // ">=" rather than "==": if div is lowered below the current count the
    // divider ticks on the next cycle instead of wrapping the whole range.
    assign tick = run && (cnt_reg >= div);

    always_comb begin
        cnt_next = cnt_reg;
        if (!run || tick) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// -----------------------------------------------------------------------------
// pwm_sample_scheduler
// Paces a valid/ready stream of signed PCM samples into the PWM modulator at
// a programmable rate. One sample is buffered; on every rate tick in RUN the
// buffered sample is converted to offset binary and presented on pcm_out.
// Starved ticks hold the last output; UNDERRUN_LIMIT consecutive starved
// ticks mute the output to midscale until the stream re-primes.
//   clk            : system clock
//   rst            : synchronous active-high reset
//   enable         : run request; low returns to IDLE and flushes the buffer
//   div            : sample period minus 1, in clk cycles
//   s_data/s_valid : signed sample input
//   s_ready        : buffer can accept a sample this cycle
//   pcm_out        : offset-binary sample to the modulator (registered)
//   sample_tick    : one-cycle pulse in the cycle pcm_out may take a new value
//   underrun_count : saturating count of starved ticks (kept across IDLE)
//   muted          : pcm_out forced to midscale by underrun or idle
// WIDTH must not exceed audio_pkg::MAX_WIDTH; UNDERRUN_LIMIT must be >= 1.
// -----------------------------------------------------------------------------
module pwm_sample_scheduler
    import audio_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DIV_WIDTH      = 16,
    parameter int UNDERRUN_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [WIDTH-1:0]     s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [WIDTH-1:0]     pcm_out,
    output logic                 sample_tick,
    output logic [15:0]          underrun_count,
    output logic                 muted
);

    localparam logic [WIDTH-1:0] MID = WIDTH'(mid_code(WIDTH));
    localparam int STARVE_W = $clog2(UNDERRUN_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(UNDERRUN_LIMIT - 1);

    sched_state_t         state_reg;
    logic [WIDTH-1:0]     buf_reg;
    logic                 buf_valid_reg;
    logic [WIDTH-1:0]     pcm_reg;
    logic                 tick_reg;
    logic                 muted_reg;
    logic [15:0]          underrun_reg;
    logic [STARVE_W-1:0]  starve_reg;

    logic                 active;
    logic                 div_tick;
    logic                 ready_next;
    logic                 accept;
    logic [WIDTH-1:0]     pcm_conv;

    // The divider only runs while the scheduler is out of IDLE and still
    // enabled, so a disable request also silences the tick in its last cycle.
    assign active = (state_reg != IDLE) && enable;

    rate_divider #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_rate_divider (
        .clk  (clk),
        .rst  (rst),
        .run  (active),
        .div  (div),
        .tick (div_tick)
    );

    // In RUN the buffer frees up on a tick, so a new sample may be taken in
    // the same edge that the old one leaves for pcm_out (no bubble).
    always_comb begin
        ready_next = 1'b0;
        case (state_reg)
            PRIME, MUTE: ready_next = !buf_valid_reg;
            RUN:         ready_next = !buf_valid_reg || div_tick;
            default:     ready_next = 1'b0;
        endcase
        // Refuse data while being disabled: it would be flushed anyway.
        ready_next = ready_next && enable;
    end

    assign accept   = s_valid && ready_next;
    assign pcm_conv = WIDTH'(signed_to_offset(MAX_WIDTH'(buf_reg), WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            buf_reg       <= '0;
            buf_valid_reg <= 1'b0;
            pcm_reg       <= MID;
            tick_reg      <= 1'b0;
            muted_reg     <= 1'b1;
            underrun_reg  <= '0;
            starve_reg    <= '0;
        end else begin
            tick_reg <= 1'b0;
            if (!enable) begin
                state_reg     <= IDLE;
                buf_valid_reg <= 1'b0;
                pcm_reg       <= MID;
                muted_reg     <= 1'b1;
                starve_reg    <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= PRIME;
                    end
                    PRIME, MUTE: begin
                        // Ticks here only pace the restart; the buffered
                        // sample is held until the first tick in RUN.
                        if (div_tick) begin
                            tick_reg <= 1'b1;
                            if (buf_valid_reg) begin
                                state_reg <= RUN;
                            end
                        end
                        if (accept) begin
                            buf_reg       <= s_data;
                            buf_valid_reg <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (div_tick) begin
                            tick_reg <= 1'b1;
                            if (buf_valid_reg) begin
                                pcm_reg    <= pcm_conv;
                                muted_reg  <= 1'b0;
                                starve_reg <= '0;
                            end else begin
                                if (underrun_reg != 16'hFFFF) begin
                                    underrun_reg <= underrun_reg + 16'd1;
                                end
                                if (starve_reg == STARVE_LAST) begin
                                    state_reg  <= MUTE;
                                    pcm_reg    <= MID;
                                    muted_reg  <= 1'b1;
                                    starve_reg <= '0;
                                end else begin
                                    starve_reg <= starve_reg + 1'b1;
                                end
                            end
                        end
                        // A load in the consuming edge keeps the buffer full.
                        if (accept) begin
                            buf_reg       <= s_data;
                            buf_valid_reg <= 1'b1;
                        end else if (div_tick && buf_valid_reg) begin
                            buf_valid_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign s_ready        = ready_next;
    assign pcm_out        = pcm_reg;
    assign sample_tick    = tick_reg;
    assign underrun_count = underrun_reg;
    assign muted          = muted_reg;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// -----------------------------------------------------------------------------
// tb_pwm_sample_scheduler
// Scoreboard bench: every accepted sample pushes its expected offset-binary
// code; the output monitor pops and compares on each non-muted sample_tick.
// Stall, disable, divider-change and reset behaviour are checked directly.
// -----------------------------------------------------------------------------
module tb_pwm_sample_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] div;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] pcm_out;
    logic        sample_tick;
    logic [15:0] underrun_count;
    logic        muted;

    pwm_sample_scheduler #(
        .WIDTH(16),
        .DIV_WIDTH(16),
        .UNDERRUN_LIMIT(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .div            (div),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .pcm_out        (pcm_out),
        .sample_tick    (sample_tick),
        .underrun_count (underrun_count),
        .muted          (muted)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] exp_q[$];
    bit  period_chk   = 1'b0;
    int  exp_period   = 0;
    int  prev_out_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Output monitor: a non-muted tick with a pending expectation is an output.
    always @(negedge clk) begin
        logic [15:0] e;
        if (sample_tick && !muted && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("out pcm=0x%04h exp=0x%04h cycle=%0d", pcm_out, e, cyc);
            check_val("pcm_out", pcm_out, e);
            if (period_chk && prev_out_cyc >= 0) begin
                check_val("tick_period", cyc - prev_out_cyc, exp_period);
            end
            prev_out_cyc = cyc;
        end
    end

    // Called just after a negedge; returns just after the negedge following
    // the transfer edge.
    task automatic feed_one(input logic [15:0] d, input int budget, input bit want_ready);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        #1;
        if (want_ready) check_val("ready_in_run", s_ready, 1'b1);
        while (!s_ready && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (s_ready) begin
            exp_q.push_back(d ^ 16'h8000);
            $display("in  sample=0x%04h cycle=%0d", d, cyc);
        end else begin
            check_val("feed_ready", s_ready, 1'b1);
        end
        @(negedge clk);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < budget);
        check_val("tick_seen", sample_tick, 1'b1);
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_pcm"}, pcm_out, 16'h8000);
        check_val({tag, "_ready"}, s_ready, 1'b0);
        check_val({tag, "_tick"}, sample_tick, 1'b0);
        check_val({tag, "_under"}, underrun_count, 16'h0000);
        check_val({tag, "_muted"}, muted, 1'b1);
    endtask

    task automatic go_idle();
        @(negedge clk);
        enable  = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check_val("idle_pcm", pcm_out, 16'h8000);
        check_val("idle_ready", s_ready, 1'b0);
        check_val("idle_muted", muted, 1'b1);
        exp_q.delete();
        period_chk   = 1'b0;
        prev_out_cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int k;
        logic [15:0] u0;

        rst = 1'b1; enable = 1'b0; div = 16'd3; s_data = '0; s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Paced stream, div=3: outputs 0x8000, 0xFFFF, 0x0000 four cycles apart.
        div = 16'd3; exp_period = 4; period_chk = 1'b1; prev_out_cyc = -1;
        @(negedge clk);
        enable = 1'b1;
        feed_one(16'h0000, 50, 1'b0);
        check_val("prime_muted", muted, 1'b1);
        feed_one(16'h7FFF, 50, 1'b0);
        feed_one(16'h8000, 50, 1'b0);
        s_valid = 1'b0;
        wait_empty(100);
        go_idle();

        // Disable with the buffer full; the buffered sample must never appear.
        div = 16'd3;
        enable = 1'b1;
        feed_one(16'h0111, 50, 1'b0);
        feed_one(16'h0222, 50, 1'b0);
        enable = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check_val("drop_pcm", pcm_out, 16'h8000);
        check_val("drop_ready", s_ready, 1'b0);
        check_val("drop_muted", muted, 1'b1);
        check_val("drop_tick", sample_tick, 1'b0);
        exp_q.delete();
        @(negedge clk);
        enable = 1'b1;
        feed_one(16'h0333, 50, 1'b0);
        s_valid = 1'b0;
        wait_empty(100);
        go_idle();

        // Divider lowered from 100 to 5 with cnt=50.
        div = 16'd100;
        enable = 1'b1;
        fork
            begin
                feed_one(16'h1001, 400, 1'b0);
                feed_one(16'h2002, 400, 1'b0);
                feed_one(16'h3003, 400, 1'b0);
                s_valid = 1'b0;
            end
            begin
                wait_tick(300);
                repeat (50) @(negedge clk);
                div = 16'd5;
                @(negedge clk);
                check_val("div_fast_tick", sample_tick, 1'b1);
                repeat (5) begin
                    @(negedge clk);
                    check_val("div_gap", sample_tick, 1'b0);
                end
                @(negedge clk);
                check_val("div_period6", sample_tick, 1'b1);
            end
        join
        wait_empty(200);
        go_idle();

        // Back-to-back stream with div=0.
        div = 16'd0;
        u0 = underrun_count;
        enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom);
            feed_one(d, 20, i >= 2);
        end
        s_valid = 1'b0;
        check_val("b2b_no_underrun", underrun_count, u0);
        wait_empty(20);
        go_idle();

        // Stall: hold, mute after 4 starved ticks, resume, then reset mid-RUN.
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst2");
        rst = 1'b0;
        div = 16'd3;
        enable = 1'b1;
        feed_one(16'h1111, 50, 1'b0);
        feed_one(16'h1234, 50, 1'b0);
        s_valid = 1'b0;
        k = 0;
        while (pcm_out != 16'h9234 && k < 10) begin
            wait_tick(20);
            k++;
        end
        check_val("stall_first", pcm_out, 16'h9234);
        for (int j = 1; j <= 3; j++) begin
            wait_tick(20);
            check_val("stall_hold", pcm_out, 16'h9234);
            check_val("stall_unmuted", muted, 1'b0);
            check_val("stall_count", underrun_count, 16'(j));
        end
        wait_tick(20);
        check_val("mute_pcm", pcm_out, 16'h8000);
        check_val("mute_muted", muted, 1'b1);
        check_val("mute_count", underrun_count, 16'd4);
        feed_one(16'h0042, 50, 1'b0);
        s_valid = 1'b0;
        wait_empty(100);
        check_val("resume_pcm", pcm_out, 16'h8042);
        check_val("resume_muted", muted, 1'b0);
        for (int j = 0; j < 3; j++) wait_tick(20);
        check_val("under7", underrun_count, 16'd7);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_run");
        rst = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_sample_scheduler.md
Name: pwm_sample_scheduler

Overview:
- Paces a stream of signed PCM samples into the PWM modulator at a programmable sample rate.
- Holds one sample in a buffer and converts two's-complement input to the offset-binary code the modulator expects.
- Handles stream underrun by holding the last output, then muting, then re-priming.
- Sits between the sample source (DMA/FIFO, valid/ready) and the PWM generator's PCM input, in the same clock domain.

Parameters:
- WIDTH, 16: sample width in bits, for both input and output.
- DIV_WIDTH, 16: width of the sample-period divider.
- UNDERRUN_LIMIT, 4: consecutive starved ticks before the output is muted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; low forces IDLE.
- div  in  DIV_WIDTH  sample period minus 1, in clk cycles (tick every div+1 cycles).
- s_data  in  WIDTH  signed sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  buffer can accept a sample.
- pcm_out  out  WIDTH  offset-binary sample to the modulator.
- sample_tick  out  1  one-cycle pulse, high in the cycle pcm_out takes a new value.
- underrun_count  out  16  saturating count of starved ticks.
- muted  out  1  high while pcm_out is forced to midscale by underrun or idle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE, pcm_out = MID (1<<(WIDTH-1), 0x8000 at default).
  - s_ready=0, sample_tick=0, underrun_count=0, muted=1.
  - Buffer empty, divider counter 0, consecutive-starve counter 0.
  - Reset asserted mid-operation overrides everything; any buffered sample is discarded.
- Handshake: a transfer occurs when s_valid && s_ready on a rising edge. s_data is ignored otherwise.
- Divider:
  - cnt runs only in PRIME/RUN/MUTE; it is held at 0 in IDLE.
  - Internal tick when cnt >= div; then cnt <= 0, else cnt <= cnt+1.
  - Using >= means a div decrease below cnt ticks on the next cycle; the new div applies from then on.
  - div=0 gives a tick every cycle.
- FSM:
  - IDLE: s_ready=0, pcm_out=MID, muted=1. enable=1 -> PRIME.
  - PRIME:
    - s_ready = !buf_valid.
    - Ticks produce no output change and no underrun count.
    - -> RUN on the tick where buf_valid=1.
  - RUN:
    - s_ready = !buf_valid || tick.
    - On tick with buffer full: pcm_out <= {~buf[WIDTH-1], buf[WIDTH-2:0]}; buffer consumed; starve counter cleared; muted=0.
    - On tick with buffer empty: pcm_out holds; underrun_count += 1, saturating at 0xFFFF; starve counter += 1.
    - Starve counter reaching UNDERRUN_LIMIT -> MUTE.
  - MUTE:
    - pcm_out <= MID, muted=1, starve counter cleared.
    - Behaves as PRIME (s_ready = !buf_valid); -> RUN on the tick where buf_valid=1.
- enable=0 in any non-IDLE state -> IDLE next cycle: buffer flushed, pcm_out <= MID, underrun_count retained.
- Simultaneous tick and handshake with buffer full in RUN: the old sample goes to pcm_out and the new sample loads the buffer in the same edge. No bubble and no loss.
- Latency:
  - pcm_out and sample_tick are registered and update one cycle after the internal tick.
  - A sample accepted at edge N appears on pcm_out no earlier than edge N+1.
- sample_tick pulses on every internal tick in PRIME/RUN/MUTE, including starved ticks.
- Conversion is a pure MSB flip. Examples: 0x8000 -> 0x0000, 0x7FFF -> 0xFFFF, 0x0000 -> 0x8000.

Decomposition:
- Shared package (audio_pkg):
  - state enum {IDLE, PRIME, RUN, MUTE}.
  - MID constant function of WIDTH.
  - signed_to_offset conversion function.
- One sub-module: rate_divider (cnt, div compare, tick), reused by later audio blocks.
- The FSM and buffer stay in the top module.

Test Plan:
- Reset then enable=1, div=3, samples 0x0000, 0x7FFF, 0x8000 always valid:
  - pcm_out goes 0x8000 -> 0xFFFF -> 0x0000 on successive ticks 4 cycles apart.
  - sample_tick aligned with each change; muted falls at the first update.
- Back-to-back stream with div=0: one sample per cycle; s_ready stays high in RUN; no underrun; output sequence equals input sequence with the MSB flipped.
- Source stalls after sample 0x1234 (pcm_out 0x9234), UNDERRUN_LIMIT=4:
  - Three ticks hold 0x9234; the fourth starved tick sets MUTE.
  - pcm_out then goes to 0x8000, underrun_count=4, muted=1.
  - Next valid sample resumes RUN.
- enable dropped mid-RUN with the buffer full: next cycle state IDLE, pcm_out=0x8000, s_ready=0; re-enable primes fresh and the old sample is never output.
- div changed from 100 to 5 while cnt=50: tick on the next cycle, then every 6 cycles.
- rst pulsed mid-RUN with underrun_count=7: all outputs return to reset values and underrun_count=0 on the following cycle.
